// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS control path.
// The optional BNEEX state is compiled in only when MC_CTRL_BNE_EN is defined.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    // ADD is the all-zero code so states that leave aluop alone compute an add.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB,
`ifdef MC_CTRL_BNE_EN
        S_BNEEX,
`endif
        S_JEX
    } state_t;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's aluop and the instruction funct field to alucontrol.
module aludec
    import mips_pkg::*;
(
    input  aluop_t      i_aluop,
    input  logic [5:0]  i_funct,
    output logic [2:0]  o_alucontrol
);

    always_comb begin
        o_alucontrol = ALUCTL_ADD;
        case (i_aluop)
            ALUOP_SUB: o_alucontrol = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FUNCT_ADD: o_alucontrol = ALUCTL_ADD;
                    FUNCT_SUB: o_alucontrol = ALUCTL_SUB;
                    FUNCT_AND: o_alucontrol = ALUCTL_AND;
                    FUNCT_OR:  o_alucontrol = ALUCTL_OR;
                    FUNCT_SLT: o_alucontrol = ALUCTL_SLT;
                    default:   o_alucontrol = ALUCTL_ADD;
                endcase
            end
            default: o_alucontrol = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS Moore control FSM with ALU decode; pcen is the only Mealy term.
// Define MC_CTRL_BNE_EN to add the BNEEX state for op 000101.
module mc_controller
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        iord,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic        pcen,
    output logic [2:0]  alucontrol
);

    state_t r_state;
    state_t w_next_state;
    aluop_t w_aluop;
    logic   w_pcwrite;
    logic   w_branch;
    logic   w_bne_branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_RTYPEEX;
                    OP_BEQ:       w_next_state = S_BEQEX;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JEX;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       w_next_state = S_BNEEX;
`endif
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next_state = S_MEMWB;
            S_RTYPEEX: w_next_state = S_RTYPEWB;
            S_ADDIEX:  w_next_state = S_ADDIWB;
            default:   w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        iord         = 1'b0;
        memwrite     = 1'b0;
        irwrite      = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_bne_branch = 1'b0;
        w_aluop      = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                alusrcb   = 2'b01;
                irwrite   = 1'b1;
                w_pcwrite = 1'b1;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_BEQEX: begin
                alusrca  = 1'b1;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
                w_aluop  = ALUOP_SUB;
            end
`ifdef MC_CTRL_BNE_EN
            S_BNEEX: begin
                alusrca      = 1'b1;
                pcsrc        = 2'b01;
                w_bne_branch = 1'b1;
                w_aluop      = ALUOP_SUB;
            end
`endif
            S_JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcen = w_pcwrite | (w_branch & zero) | (w_bne_branch & ~zero);

    aludec u_aludec (
        .i_aluop      (w_aluop),
        .i_funct      (funct),
        .o_alucontrol (alucontrol)
    );

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port op, input, 6, instruction opcode field [31:26].
REQ-004 SHALL have port funct, input, 6, instruction funct field [5:0].
REQ-005 SHALL have port zero, input, 1, ALU zero flag.
REQ-006 SHALL have outputs iord, memwrite, irwrite, regdst, memtoreg, regwrite and alusrca, each 1 bit: datapath select and write strobes.
REQ-007 SHALL have outputs alusrcb (2 bits) and pcsrc (2 bits): mux selects.
REQ-008 SHALL have output pcen, 1 bit: PC register enable.
REQ-009 SHALL have output alucontrol, 3 bits, driven to the ALU: add=010, sub=110, and=000, or=001, slt=111.

Function
REQ-010 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB and JEX, using one state per clock.
REQ-011 Transitions SHALL be:
- FETCH->DECODE.
- DECODE->MEMADR (lw 100011, sw 101011), RTYPEEX (000000), BEQEX (000100), ADDIEX (001000), JEX (000010).
- DECODE->FETCH for any other opcode; the instruction is silently dropped.
- MEMADR->MEMRD for lw; MEMADR->MEMWR for sw.
- MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX each go to FETCH.
REQ-012 SHALL drive outputs per state; every output not listed is 0.
- FETCH: alusrcb=01, irwrite=1, pcwrite=1, aluop=add.
- DECODE: alusrcb=11, aluop=add.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=add.
- MEMRD: iord=1.
- MEMWR: iord=1, memwrite=1.
- MEMWB: memtoreg=1, regwrite=1.
- RTYPEEX: alusrca=1, aluop=funct.
- RTYPEWB: regdst=1, regwrite=1.
- ADDIWB: regwrite=1.
- BEQEX: alusrca=1, pcsrc=01, branch=1, aluop=sub.
- JEX: pcsrc=10, pcwrite=1.
REQ-013 SHALL compute pcen = pcwrite | (branch & zero) combinationally, the only output that depends on an input in the same cycle.
REQ-014 SHALL set alucontrol from aluop as follows: add->010, sub->110.
REQ-015 For aluop=funct, alucontrol SHALL be decoded from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, and any other funct->010.
REQ-016 Instruction latency SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles (FETCH through return to FETCH).
REQ-017 op and funct SHALL be sampled only in DECODE, MEMADR and RTYPEEX; changes to them in other states SHALL have no effect.

Reset
REQ-018 Asserting reset SHALL force state to FETCH immediately, with no clock edge required, including mid-instruction; no partial writeback SHALL occur after assertion.
REQ-019 While reset is high, outputs SHALL equal the FETCH values: irwrite=1, pcen=1, alusrcb=01, alucontrol=010, all others 0.
REQ-020 The first rising edge after reset deasserts SHALL move the FSM to DECODE.

Configuration
REQ-021 With macro MC_CTRL_BNE_EN defined, the block SHALL add state BNEEX, entered from DECODE on op 000101.
REQ-022 BNEEX SHALL drive the same outputs as BEQEX, except pcen = pcwrite | (bne_branch & ~zero), and SHALL return to FETCH.
REQ-023 Without MC_CTRL_BNE_EN, op 000101 SHALL be treated as unsupported (DECODE->FETCH) and no BNEEX logic SHALL exist.

Structure
REQ-024 Package mips_pkg SHALL hold the opcode constants, funct constants, the 3-bit alucontrol encodings, the 2-bit aluop enum and the state enum.
REQ-025 The aluop/funct->alucontrol mapping SHALL live in a combinational sub-module aludec; the FSM and output logic SHALL live in mc_controller.

Verification
REQ-026 Reset pulse mid-MEMRD -> state FETCH immediately, irwrite=1, pcen=1, memwrite=0, regwrite=0.
REQ-027 op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-028 op=000000 with funct=101010 -> alucontrol=111 in RTYPEEX; regdst=1 and regwrite=1 in RTYPEWB.
REQ-029 op=000100 in BEQEX: zero=1 -> pcen=1, pcsrc=01; zero=0 -> pcen=0; next state FETCH in both cases.
REQ-030 op=111111 -> FETCH, DECODE, FETCH; no write strobe asserted.
REQ-031 op=000101 -> pcen=~zero in BNEEX with MC_CTRL_BNE_EN defined; dropped as in REQ-030 without it.
